// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: memory stage running 32-bit loads/stores as two 16-bit SRAM phases; MEM_RANGE_CHECK_EN enables address range checking
module mem_stage_sram_ctrl #(
  parameter int ADDR_LEN    = 32,
  parameter int SRAM_ADDR_W = 18,
  parameter int SRAM_WAIT   = 1,
  parameter int MEM_BASE    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_LEN-1:0]    alu_res,
  input  logic [ADDR_LEN-1:0]    val_rm,
  input  logic                   mem_w_en,
  input  logic                   mem_r_en,
  input  logic                   wb_en,
  input  logic [3:0]             dest,
  output logic                   wb_en_out,
  output logic [3:0]             dest_out,
  output logic [ADDR_LEN-1:0]    alu_res_out,
  output logic [ADDR_LEN-1:0]    mem_rdata,
  output logic                   ready,
  output logic                   addr_err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;
  state_t state, state_n, cur;
  logic [2:0] cnt, cnt_n, cur_cnt;
  logic [15:0] buf_lo;
  logic [SRAM_ADDR_W-2:0] word;
  logic req, bad, last, ph, hi, wr;
  assign wb_en_out = wb_en;
  assign dest_out = dest;
  assign alu_res_out = alu_res;
  assign req = mem_w_en | mem_r_en;
  assign word = (SRAM_ADDR_W-1)'((alu_res - ADDR_LEN'(MEM_BASE)) >> 2);
  assign ready = (state == IDLE && !req) || state == DONE;
`ifdef MEM_RANGE_CHECK_EN
  localparam logic [ADDR_LEN:0] LO_LIM = (ADDR_LEN+1)'(MEM_BASE);
  localparam logic [ADDR_LEN:0] HI_LIM = LO_LIM + ((ADDR_LEN+1)'(4) << (SRAM_ADDR_W-1));
  logic err;
  assign bad = {1'b0, alu_res} < LO_LIM || {1'b0, alu_res} >= HI_LIM || alu_res[1:0] != 2'b00;
  // a rejected request always lands in DONE next, so the flag marks exactly that cycle
  always_ff @(posedge clk) err <= !rst && state == IDLE && req && bad;
  assign addr_err = err;
`else
  assign bad = 1'b0;
  assign addr_err = 1'b0;
`endif
  // an accepted request in IDLE already acts as the first cycle of its LO phase
  always_comb begin
    cur = (state == IDLE && req && !bad) ? (mem_w_en ? WR_LO : RD_LO) : state;
    cur_cnt = state == IDLE ? 3'd0 : cnt;
    last = cur_cnt == 3'(SRAM_WAIT);
    ph = cur != IDLE && cur != DONE;
    hi = cur == WR_HI || cur == RD_HI;
    wr = cur == WR_LO || cur == WR_HI;
    state_n = cur == IDLE ? (req ? DONE : IDLE) : cur == DONE ? IDLE : !last ? cur :
              cur == WR_LO ? WR_HI : cur == RD_LO ? RD_HI : DONE;
    cnt_n = (ph && !last) ? cur_cnt + 3'd1 : 3'd0;
    sram_we_n = rst || !wr;
    sram_dq_oe = !rst && wr;
    sram_addr = (!rst && ph) ? {word, hi} : '0;
    sram_dq_out = (!rst && wr) ? (hi ? val_rm[31:16] : val_rm[15:0]) : 16'h0;
  end
  // state register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    cnt <= rst ? 3'd0 : cnt_n;
  end
  // capture read halves at the end of each phase; the result only moves when a load finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_lo <= 16'h0;
      mem_rdata <= '0;
    end else begin
      if (cur == RD_LO && last) buf_lo <= sram_dq_in;
      if (cur == RD_HI && last) mem_rdata <= {sram_dq_in, buf_lo};
      else if (state == IDLE && bad && mem_r_en && !mem_w_en) mem_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: random and directed loads/stores checked against a transaction-level model and SRAM model
module tb_mem_stage_sram_ctrl;
  localparam int SRAM_WAIT = 1;
  localparam int W = SRAM_WAIT + 1;
  localparam int MEM_BASE = 1024;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] alu_res = '0, val_rm = '0, alu_res_out, mem_rdata;
  logic mem_w_en = 1'b0, mem_r_en = 1'b0, wb_en = 1'b0, wb_en_out, ready, addr_err;
  logic [3:0] dest = '0, dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic sram_dq_oe, sram_we_n;
  typedef struct packed {
    logic rdy; logic we_n; logic oe; logic err;
    logic [17:0] addr; logic [15:0] dq; logic [31:0] rdata;
  } exp_t;
  exp_t q[$];
  exp_t e_c;
  logic [31:0] ref_mem [int];
  logic [31:0] m_rdata = '0;
  logic [15:0] sram [0:262143];
  bit clr_done = 1'b0;
  int run = 0;
  logic [17:0] last_a = '0;
  int n_chk = 0, n_pass = 0;

  mem_stage_sram_ctrl #(.ADDR_LEN(32), .SRAM_ADDR_W(18), .SRAM_WAIT(SRAM_WAIT), .MEM_BASE(MEM_BASE)) dut (
    .clk(clk), .rst(rst), .alu_res(alu_res), .val_rm(val_rm), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .wb_en(wb_en), .dest(dest), .wb_en_out(wb_en_out), .dest_out(dest_out), .alu_res_out(alu_res_out),
    .mem_rdata(mem_rdata), .ready(ready), .addr_err(addr_err), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n));

  always #5 clk = ~clk;

  assign sram_dq_in = sram[sram_addr];

  // SRAM commits a half-word only after we_n has been held low on one address for a full phase
  always @(posedge clk) begin
    if (!clr_done) begin
      for (int i = 0; i < 262144; i++) sram[i] <= 16'h0;
      clr_done <= 1'b1;
    end else if (!sram_we_n && ((sram_addr == last_a && run > 0) ? run + 1 : 1) == W) sram[sram_addr] <= sram_dq_out;
    run <= sram_we_n ? 0 : (sram_addr == last_a && run > 0) ? run + 1 : 1;
    last_a <= sram_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_get(input logic [31:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // every cycle with a queued expectation, compare all outputs
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_c = q.pop_front();
      chk("ready", 32'(ready), 32'(e_c.rdy));
      chk("we_n", 32'(sram_we_n), 32'(e_c.we_n));
      chk("oe", 32'(sram_dq_oe), 32'(e_c.oe));
      chk("addr_err", 32'(addr_err), 32'(e_c.err));
      chk("sram_addr", 32'(sram_addr), 32'(e_c.addr));
      chk("sram_dq_out", 32'(sram_dq_out), 32'(e_c.dq));
      chk("mem_rdata", mem_rdata, e_c.rdata);
      chk("wb_en_out", 32'(wb_en_out), 32'(wb_en));
      chk("dest_out", 32'(dest_out), 32'(dest));
      chk("alu_res_out", alu_res_out, alu_res);
    end
  end

  task automatic push(input logic rdy, input logic we_n, input logic oe, input logic err,
                      input logic [17:0] addr, input logic [15:0] dq);
    exp_t e;
    e.rdy = rdy; e.we_n = we_n; e.oe = oe; e.err = err;
    e.addr = addr; e.dq = dq; e.rdata = m_rdata;
    q.push_back(e);
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic wb, input logic [3:0] dst);
    @(posedge clk);
    #1;
    mem_w_en = w; mem_r_en = r; alu_res = a; val_rm = d; wb_en = wb; dest = dst;
  endtask

  task automatic idle_cyc();
    drive(1'b0, 1'b0, $urandom, $urandom, 1'($urandom), 4'($urandom));
    push(1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0);
  endtask

  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wd;
    logic bad, wr, rd, wb;
    logic [3:0] dst;
    wd = ((a - 32'(MEM_BASE)) / 32'd4) % 32'd131072;
    wr = w;
    rd = r && !w;
    bad = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    bad = a < 32'(MEM_BASE) || a >= 32'(MEM_BASE) + 32'd524288 || a % 4 != 0;
`endif
    wb = 1'($urandom);
    dst = 4'($urandom);
    if (bad) begin
      drive(w, r, a, d, wb, dst);
      push(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0);
      if (rd) m_rdata = 32'h0;
      drive(w, r, a, d, wb, dst);
      push(1'b1, 1'b1, 1'b0, 1'b1, '0, 16'h0);
      return;
    end
    for (int c = 0; c < 2 * W; c++) begin
      drive(w, r, a, d, wb, dst);
      push(1'b0, !wr, wr, 1'b0, {wd[16:0], c >= W}, wr ? (c >= W ? d[31:16] : d[15:0]) : 16'h0);
    end
    if (wr) ref_mem[wd] = d;
    if (rd) m_rdata = ref_get(wd);
    drive(w, r, a, d, wb, dst);
    push(1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0);
  endtask

  initial begin
    logic [31:0] old, a;
    int kind;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_cyc();
    op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    idle_cyc();
    chk("store_lo_half", 32'(sram[0]), 32'h0000BEEF);
    chk("store_hi_half", 32'(sram[1]), 32'h0000DEAD);
    op(1'b0, 1'b1, 32'd1024, 32'h0);
    idle_cyc();
    chk("load_back", mem_rdata, 32'hDEADBEEF);
    op(1'b1, 1'b1, 32'd1028, 32'h12345678);
    idle_cyc();
    chk("both_lo_half", 32'(sram[2]), 32'h00005678);
    chk("both_hi_half", 32'(sram[3]), 32'h00001234);
    chk("both_rdata_kept", mem_rdata, 32'hDEADBEEF);
    old = ref_get(32'd4);
    for (int c = 0; c < 2 * W; c++) begin
      drive(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 1'b1, 4'h3);
      if (c == 2 * W - 1) begin
        rst = 1'b1;
        push(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0);
      end else push(1'b0, 1'b0, 1'b1, 1'b0, {17'd4, c >= W}, c >= W ? 16'hCAFE : 16'hF00D);
    end
    ref_mem[4] = {old[31:16], 16'hF00D};
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'h0);
    rst = 1'b0;
    m_rdata = 32'h0;
    push(1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_lo_written", 32'(sram[8]), 32'h0000F00D);
    chk("reset_hi_unwritten", 32'(sram[9]), 32'h00000000);
    op(1'b0, 1'b1, 32'd1032, 32'h0);
    op(1'b1, 1'b0, 32'd1036, 32'hA5A55A5A);
    idle_cyc();
    chk("b2b_hi_half", 32'(sram[7]), 32'h0000A5A5);
`ifdef MEM_RANGE_CHECK_EN
    op(1'b0, 1'b1, 32'd1000, 32'h0);
    idle_cyc();
    chk("range_rdata", mem_rdata, 32'h0);
`endif
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      a = 32'(MEM_BASE) + 32'd4 * (32'($urandom_range(8, 23)) + ($urandom_range(0, 3) == 0 ? 32'd131072 : 32'd0));
      if ($urandom_range(0, 9) == 0) a = $urandom & 32'hFFFF_FFFC;
      if (kind == 0) idle_cyc();
      else op(kind != 2, kind != 1, a, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cyc();
    end
    idle_cyc();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
